// File: rtl/input_conditioner.sv
// input_conditioner: N-channel pin front end with sync, debounce, polarity, edge pulses, auto-repeat.
// Auto-repeat exists only when INPUT_COND_REPEAT_EN is defined; otherwise press mirrors rise.
module input_conditioner #(
  parameter int unsigned  N             = 5,
  parameter int unsigned  DB_CYCLES     = 100000000,
  parameter logic [N-1:0] INVERT        = '0,
  parameter logic [N-1:0] RESET_LEVEL   = '0,
  parameter int unsigned  REPEAT_DELAY  = 50000000,
  parameter int unsigned  REPEAT_PERIOD = 10000000,
  parameter logic [N-1:0] REPEAT_MASK   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] press
);

  localparam int unsigned     DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

`ifdef INPUT_COND_REPEAT_EN
  localparam int unsigned      REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned      REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] RD_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RP_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

  if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || $bits(REPEAT_MASK) != N)
  begin : g_bad_cfg
    $error("input_conditioner: DB_CYCLES/REPEAT_* must be >= 1 and masks N bits wide");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic            sync1;
    logic            sync2;
    logic            lvl;
    logic [DB_W-1:0] db_cnt;
    logic            toggle;
    logic            rise_q;
    logic            fall_q;

    // NOTE: the synchroniser resets to the same value as the level flop, so reset
    // release never looks like a pin change and produces no spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= RESET_LEVEL[i];
        sync2 <= RESET_LEVEL[i];
      end else begin
        sync1 <= raw[i] ^ INVERT[i];
        sync2 <= sync1;
      end
    end

    // The count reaching DB_CYCLES and the level flip happen on one edge.
    assign toggle = (sync2 != lvl) && (db_cnt == DB_LAST);

    // NOTE: non-blocking assignments throughout, so every flop samples the
    // pre-edge value of lvl/db_cnt regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl    <= RESET_LEVEL[i];
        db_cnt <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= toggle & ~lvl;
        fall_q <= toggle & lvl;
        if (sync2 == lvl || toggle) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
        if (toggle) begin
          lvl <= ~lvl;
        end
      end
    end

    assign level[i] = lvl;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

`ifdef INPUT_COND_REPEAT_EN
    logic rep_hit;
    logic press_q;

    if (REPEAT_MASK[i]) begin : g_rep
      logic [REP_W-1:0] rep_cnt;
      logic             rep_periodic;

      // A falling edge (toggle while high) suppresses any repeat due on that edge.
      assign rep_hit = lvl && !toggle &&
                       (rep_periodic ? (rep_cnt == RP_LAST) : (rep_cnt == RD_LAST));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rep_cnt      <= '0;
          rep_periodic <= 1'b0;
        end else if (!lvl || toggle) begin
          rep_cnt      <= '0;
          rep_periodic <= 1'b0;
        end else if (rep_hit) begin
          rep_cnt      <= '0;
          rep_periodic <= 1'b1;
        end else begin
          rep_cnt      <= rep_cnt + REP_W'(1);
        end
      end
    end else begin : g_no_rep
      assign rep_hit = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        press_q <= 1'b0;
      end else begin
        press_q <= (toggle & ~lvl) | rep_hit;
      end
    end

    assign press[i] = press_q;
`else
    assign press[i] = rise_q;
`endif
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: sliding-window reference model compared every
// cycle, plus directed literal checks on latency, glitch rejection, inversion, repeat, reset.
module tb_input_conditioner;

  localparam int          N     = 4;
  localparam int          DB    = 4;
  localparam logic [N-1:0] INV  = 4'b1000;
  localparam logic [N-1:0] RLVL = 4'b0010;
  localparam int          RD    = 10;
  localparam int          RP    = 3;
  localparam logic [N-1:0] RMASK = 4'b0001;
`ifdef INPUT_COND_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] press;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .N(N), .DB_CYCLES(DB), .INVERT(INV), .RESET_LEVEL(RLVL),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(RMASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw(raw),
    .level(level), .rise(rise), .fall(fall), .press(press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pin delayed two edges, level flips once the last DB samples all disagree.
  logic [N-1:0] dl1, dl2;
  logic [N-1:0] win[$];
  logic [N-1:0] m_level, m_rise, m_fall, m_press;
  int           cyc;
  int           t_rise[N];

  task automatic model_reset();
    dl1 = RLVL;
    dl2 = RLVL;
    win.delete();
    m_level = RLVL;
    m_rise  = '0;
    m_fall  = '0;
    m_press = '0;
    for (int i = 0; i < N; i++) t_rise[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] pin);
    logic [N-1:0] tog, nl, rp;
    int d;
    win.push_back(dl2);
    if (win.size() > DB) void'(win.pop_front());
    for (int i = 0; i < N; i++) begin
      tog[i] = (win.size() == DB);
      for (int j = 0; j < win.size(); j++) begin
        if (win[j][i] == m_level[i]) tog[i] = 1'b0;
      end
      d = cyc - t_rise[i];
      rp[i] = REP_EN && RMASK[i] && m_level[i] && !tog[i] && (d >= RD) && (((d - RD) % RP) == 0);
    end
    nl      = m_level ^ tog;
    m_rise  = tog & nl;
    m_fall  = tog & m_level;
    m_press = m_rise | rp;
    for (int i = 0; i < N; i++) if (m_rise[i]) t_rise[i] = cyc;
    m_level = nl;
    dl2 = dl1;
    dl1 = pin ^ INV;
    cyc++;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(raw);
      #1;
      check("cmp_level", level, m_level);
      check("cmp_rise",  rise,  m_rise);
      check("cmp_fall",  fall,  m_fall);
      check("cmp_press", press, m_press);
    end
  end

  task automatic mid_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_level"}, level, RLVL);
    check({tag, "_pulses"}, rise | fall | press, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full DB+2 latency after reset release with ch0 held high at the pin.
  task automatic post_reset_latency(input string tag);
    repeat (5) @(posedge clk);
    #2 check({tag, "_early"}, level[0], 1'b0);
    @(posedge clk);
    #2 check({tag, "_rise"}, rise, 4'b0001);
  endtask

  initial begin
    logic [N-1:0] seen;
    rst_n = 1'b0;
    raw   = 4'b1010;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Reset state holds quietly for 20 cycles.
    seen = '0;
    repeat (20) begin
      @(posedge clk);
      #2 seen |= rise | fall | press;
    end
    check("rst_level", level, 4'b0010);
    check("rst_quiet", seen, 0);

    // Clean edge on ch0: accepted exactly on edge E0+5.
    @(negedge clk); raw = 4'b1011;
    repeat (5) @(posedge clk);
    #2 check("clean_early", level, 4'b0010);
    @(posedge clk);
    #2 check("clean_level", level, 4'b0011);
    check("clean_rise", rise, 4'b0001);
    check("clean_fall", fall, 4'b0000);
    @(posedge clk);
    #2 check("clean_one_shot", rise, 4'b0000);

    // Glitch of DB-1 samples on ch2 is rejected.
    @(negedge clk); raw = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk); raw = 4'b1011;
    repeat (10) @(posedge clk);
    #2 check("glitch_level", level[2], 1'b0);

    // Exactly DB samples are accepted; drop gives fall 6 edges later.
    @(negedge clk); raw = 4'b1111;
    repeat (4) @(posedge clk);
    @(negedge clk); raw = 4'b1011;
    repeat (2) @(posedge clk);
    #2 check("accept_rise", rise, 4'b0100);
    repeat (3) @(posedge clk);
    #2 check("accept_hold", level[2], 1'b1);
    @(posedge clk);
    #2 check("accept_fall", fall, 4'b0100);
    repeat (3) @(posedge clk);

    // Inversion on ch3 and simultaneous edges across channels.
    @(negedge clk); raw = 4'b0111;
    repeat (6) @(posedge clk);
    #2 check("inv_rise", rise, 4'b1100);
    check("inv_level", level, 4'b1111);
    @(negedge clk); raw = 4'b1000;
    repeat (6) @(posedge clk);
    #2 check("inv_fall", fall, 4'b1111);
    check("inv_level0", level, 4'b0000);
    repeat (3) @(posedge clk);

    // Auto-repeat on ch0 only; ch1 held identically.
    @(negedge clk); raw = 4'b1011;
    repeat (6) @(posedge clk);
    #2 check("rep_t", press, 4'b0011);
    repeat (9) @(posedge clk);
    #2 check("rep_t9", press, 4'b0000);
    @(posedge clk);
    #2 check("rep_t10", press, REP_EN ? 4'b0001 : 4'b0000);
    repeat (3) @(posedge clk);
    #2 check("rep_t13", press, REP_EN ? 4'b0001 : 4'b0000);
    repeat (3) @(posedge clk);
    #2 check("rep_t16", press, REP_EN ? 4'b0001 : 4'b0000);
    @(negedge clk); raw = 4'b1000;
    repeat (3) @(posedge clk);
    #2 check("rep_t19", press, REP_EN ? 4'b0001 : 4'b0000);
    repeat (3) @(posedge clk);
    #2 check("rep_fall_wins", {fall, press}, {4'b0011, 4'b0000});
    repeat (10) @(posedge clk);

    // Reset during repeat hold, then full latency again.
    @(negedge clk); raw = 4'b1011;
    repeat (18) @(posedge clk);
    mid_reset("rst_hold");
    post_reset_latency("rst_hold");
    @(negedge clk); raw = 4'b1000;
    repeat (12) @(posedge clk);

    // Reset with ch0 debounce count at 2 of 4.
    @(negedge clk); raw = 4'b1001;
    repeat (4) @(posedge clk);
    mid_reset("rst_count");
    post_reset_latency("rst_count");

    // Random phase: mixed flip rates, occasional reset.
    for (int seg = 0; seg < 3; seg++) begin
      for (int k = 0; k < 1500; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 99) < 5 + seg * 10) raw[$urandom_range(0, N - 1)] ^= 1'b1;
        if ($urandom_range(0, 599) == 0) begin
          rst_n = 1'b0;
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
        end
      end
    end

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
